clock_enable_generator: RTL and testbench

Parametrised, synthesisable successor to the bench clock/reset source: from the single system clock it produces a stretched synchronous reset for downstream logic and `CHANNELS` independent one-cycle clock-enable ticks, each with a programmable divide ratio. Layer, activation and data-loader pipelines use these ticks to run at sub-rates without extra clock domains. It sits at the top of the design next to the clock input and feeds every rate-controlled block.

---
 rtl/clock_enable_pkg.sv | 18 +
 rtl/clock_enable_channel.sv | 87 ++++++++
 rtl/clock_enable_generator.sv | 89 ++++++++
 tb/tb_clock_enable_generator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_enable_pkg.sv
// Shared definitions for the clock-enable generator.
//   state_t      : controller states (HOLD while reset is stretched, IDLE, RUN)
//   divider_t    : divide/phase value at the default DIVIDER_WIDTH
//   MAX_CHANNELS : largest supported channel count
package clock_enable_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DIVIDER_WIDTH_DEFAULT = 16;
  typedef logic [DIVIDER_WIDTH_DEFAULT-1:0] divider_t;

  localparam int MAX_CHANNELS = 16;

endpackage

// File: rtl/clock_enable_channel.sv
// One tick channel: latched divide ratio (and start phase when
// CLOCK_ENABLE_PHASE_EN is defined), a free-running counter and a
// registered one-cycle tick.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   load         : latch divide (and phase); counter restarts at the phase
//   run          : advance the counter this edge; otherwise hold at phase
//   divide       : new divide ratio D (0 disables the channel)
//   phase        : new start offset (only with CLOCK_ENABLE_PHASE_EN)
//   tick         : registered clock-enable, high one cycle every D edges
module clock_enable_channel
  import clock_enable_pkg::*;
#(
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     run,
  input  logic [DIVIDER_WIDTH-1:0] divide,
`ifdef CLOCK_ENABLE_PHASE_EN
  input  logic [DIVIDER_WIDTH-1:0] phase,
`endif
  output logic                     tick
);

  logic [DIVIDER_WIDTH-1:0] div_q;
  logic [DIVIDER_WIDTH-1:0] cnt_q;
  logic [DIVIDER_WIDTH-1:0] ph_new;
  logic [DIVIDER_WIDTH-1:0] ph_cur;
  logic                     tick_q;

`ifdef CLOCK_ENABLE_PHASE_EN
  logic [DIVIDER_WIDTH-1:0] ph_q;

  // A start offset at or beyond D would never match D-1; pin it to D-1.
  function automatic logic [DIVIDER_WIDTH-1:0] clamp_phase(
    input logic [DIVIDER_WIDTH-1:0] d,
    input logic [DIVIDER_WIDTH-1:0] p
  );
    if (d == '0)     return '0;
    else if (p >= d) return d - DIVIDER_WIDTH'(1);
    else             return p;
  endfunction

  assign ph_new = clamp_phase(divide, phase);
  assign ph_cur = ph_q;

  always_ff @(posedge clock) begin
    if (reset)     ph_q <= '0;
    else if (load) ph_q <= ph_new;
  end
`else
  assign ph_new = '0;
  assign ph_cur = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (load) begin
      // Restart edge: never issues a tick.
      div_q  <= divide;
      cnt_q  <= ph_new;
      tick_q <= 1'b0;
    end else if (run) begin
      if (div_q == '0) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else if (cnt_q == div_q - DIVIDER_WIDTH'(1)) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + DIVIDER_WIDTH'(1);
        tick_q <= 1'b0;
      end
    end else begin
      cnt_q  <= ph_cur;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clock_enable_generator.sv
// Clock-enable generator: stretches the incoming synchronous reset and
// drives CHANNELS independent divide-by-D tick channels.
// Optional feature macro: CLOCK_ENABLE_PHASE_EN adds the per-channel
// phase input (start offset, latched with load).
// Ports:
//   clock     : system clock
//   reset     : synchronous active-high reset
//   enable    : 1 = run channels, 0 = idle
//   load      : one-cycle pulse latching divide (and phase)
//   divide    : CHANNELS x DIVIDER_WIDTH divide ratios
//   phase     : CHANNELS x DIVIDER_WIDTH start offsets (optional)
//   reset_out : stretched reset, low RESET_CYCLES edges after reset falls
//   running   : high while in RUN
//   tick      : per-channel registered clock-enables
module clock_enable_generator
  import clock_enable_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int DIVIDER_WIDTH = 16,
  parameter int RESET_CYCLES  = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              load,
  input  logic [CHANNELS*DIVIDER_WIDTH-1:0] divide,
`ifdef CLOCK_ENABLE_PHASE_EN
  input  logic [CHANNELS*DIVIDER_WIDTH-1:0] phase,
`endif
  output logic                              reset_out,
  output logic                              running,
  output logic [CHANNELS-1:0]               tick
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                ch_load;
  logic                ch_run;

  always_comb begin
    state_nxt = state;
    case (state)
      HOLD:    if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_nxt = IDLE;
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      reset_out <= 1'b1;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (state == HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
      // Outputs registered from the next state so they change on the
      // same edge as the state itself.
      reset_out <= (state_nxt == HOLD);
      running   <= (state_nxt == RUN);
    end
  end

  // Load is ignored while the reset is still being stretched; channels
  // advance only on edges that stay in RUN.
  assign ch_load = load && (state != HOLD);
  assign ch_run  = (state == RUN) && enable;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clock_enable_channel #(
      .DIVIDER_WIDTH(DIVIDER_WIDTH)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .load   (ch_load),
      .run    (ch_run),
      .divide (divide[i*DIVIDER_WIDTH +: DIVIDER_WIDTH]),
`ifdef CLOCK_ENABLE_PHASE_EN
      .phase  (phase[i*DIVIDER_WIDTH +: DIVIDER_WIDTH]),
`endif
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_clock_enable_generator.sv
module tb_clock_enable_generator;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int RC = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              load = 1'b0;
  logic [CH*DW-1:0]  divide = '0;
  logic [CH*DW-1:0]  phase_v = '0;
  logic              reset_out;
  logic              running;
  logic [CH-1:0]     tick;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0=HOLD 1=IDLE 2=RUN; ticks computed from the
  // edge count since the last restart (RUN entry or load in RUN).
  int mode = 0;
  int hc = 0;
  int n = 0;
  int start = 0;
  int md[CH];
  int mp[CH];

  always #5 clock = ~clock;

  clock_enable_generator #(
    .CHANNELS(CH), .DIVIDER_WIDTH(DW), .RESET_CYCLES(RC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .divide    (divide),
`ifdef CLOCK_ENABLE_PHASE_EN
    .phase     (phase_v),
`endif
    .reset_out (reset_out),
    .running   (running),
    .tick      (tick)
  );

  function automatic logic [CH*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [CH*DW-1:0] v;
    v = '0;
    v[0*DW +: DW] = DW'(a);
    v[1*DW +: DW] = DW'(b);
    v[2*DW +: DW] = DW'(c);
    v[3*DW +: DW] = DW'(d);
    return v;
  endfunction

  task automatic latch_model(input logic [CH*DW-1:0] dv, input logic [CH*DW-1:0] pv);
    for (int i = 0; i < CH; i++) begin
      md[i] = int'(dv[i*DW +: DW]);
`ifdef CLOCK_ENABLE_PHASE_EN
      mp[i] = int'(pv[i*DW +: DW]);
`else
      mp[i] = 0;
`endif
      if (md[i] == 0) mp[i] = 0;
      else if (mp[i] >= md[i]) mp[i] = md[i] - 1;
    end
  endtask

  task automatic model_edge();
    n++;
    if (reset) begin
      mode = 0; hc = 0;
      for (int i = 0; i < CH; i++) begin md[i] = 0; mp[i] = 0; end
    end else begin
      case (mode)
        0: begin hc++; if (hc == RC) mode = 1; end
        1: begin
          if (load) latch_model(divide, phase_v);
          if (enable) begin mode = 2; start = n; end
        end
        default: begin
          if (load) begin latch_model(divide, phase_v); start = n; end
          if (!enable) mode = 1;
        end
      endcase
    end
  endtask

  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] t;
    int k, fp;
    t = '0;
    for (int i = 0; i < CH; i++) begin
      if (mode == 2 && md[i] > 0) begin
        k  = n - start;
        fp = md[i] - mp[i];
        if (k >= fp && ((k - fp) % md[i]) == 0) t[i] = 1'b1;
      end
    end
    return t;
  endfunction

  task automatic step(input logic r, input logic e, input logic l,
                      input logic [CH*DW-1:0] dv, input logic [CH*DW-1:0] pv);
    reset = r; enable = e; load = l; divide = dv; phase_v = pv;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 1'b1, pack4(1, 1, 1, 1), '0);
      total++;
      if (reset_out !== 1'b1 || running !== 1'b0 || tick !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got rout=%b run=%b tick=%b want rout=1 run=0 tick=0",
                 c, reset_out, running, tick);
      end
    end
    // load/enable asserted during HOLD must be ignored.
    for (int k = 1; k <= RC + 2; k++) begin
      step(1'b0, 1'b0, 1'b1, pack4(1, 1, 1, 1), '0);
      total++;
      if (reset_out !== (k < RC) || running !== 1'b0 || tick !== '0) begin
        bad++;
        $display("FAIL reset_release edge=%0d got rout=%b run=%b tick=%b want rout=%b run=0 tick=0",
                 k, reset_out, running, tick, (k < RC));
      end
    end
  endtask

  task automatic test_divide();
    step(1'b0, 1'b1, 1'b1, pack4(1, 2, 3, 0), '0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, 1'b0, pack4(1, 2, 3, 0), '0);
      total++;
      // Independent expectation: ch0 every edge, ch1 even edges, ch2 every 3rd, ch3 never.
      if (tick !== {1'b0, (k % 3 == 0), (k % 2 == 0), 1'b1} || tick !== exp_tick() || running !== 1'b1) begin
        bad++;
        $display("FAIL divide edge=%0d got tick=%b run=%b want tick=%b run=1",
                 k, tick, running, exp_tick());
      end
    end
  endtask

`ifdef CLOCK_ENABLE_PHASE_EN
  task automatic test_phase();
    logic [CH-1:0] want;
    step(1'b0, 1'b0, 1'b1, pack4(4, 4, 4, 4), pack4(0, 1, 3, 7));
    step(1'b0, 1'b1, 1'b0, pack4(4, 4, 4, 4), pack4(0, 1, 3, 7));
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      want = {(k % 4 == 1), (k % 4 == 1), (k % 4 == 3), (k % 4 == 0)};
      total++;
      if (tick !== want || tick !== exp_tick()) begin
        bad++;
        $display("FAIL phase edge=%0d got tick=%b want=%b", k, tick, want);
      end
    end
  endtask
`endif

  task automatic test_enable_toggle();
    logic [CH-1:0] first[8];
    logic [CH-1:0] second[8];
    step(1'b0, 1'b0, 1'b1, pack4(2, 3, 5, 1), pack4(1, 2, 9, 0));
    step(1'b0, 1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      first[k] = tick;
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      total++;
      if (tick !== '0 || running !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet cyc=%0d got tick=%b run=%b want tick=0 run=0", k, tick, running);
      end
    end
    step(1'b0, 1'b1, 1'b0, '0, '0);
    total++;
    if (running !== 1'b1 || tick !== '0) begin
      bad++;
      $display("FAIL rerun_entry got run=%b tick=%b want run=1 tick=0", running, tick);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      second[k] = tick;
      total++;
      if (second[k] !== first[k] || tick !== exp_tick()) begin
        bad++;
        $display("FAIL restart_pattern edge=%0d got tick=%b want=%b", k + 1, second[k], first[k]);
      end
    end
  endtask

  task automatic test_load_midrun();
    int found;
    step(1'b0, 1'b1, 1'b1, pack4(3, 0, 0, 0), '0);
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      if (tick[0] === 1'b1) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL load_mid_seek got no tick within 6 edges want a tick");
    end
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, pack4(5, 0, 0, 0), '0);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step(1'b0, 1'b1, 1'b0, '0, '0);
      total++;
      if (tick[0] !== (k == 5) || tick !== exp_tick()) begin
        bad++;
        $display("FAIL load_mid edge=%0d after load got tick0=%b want=%b", k, tick[0], (k == 5));
      end
    end
  endtask

  task automatic test_reset_in_run();
    step(1'b0, 1'b1, 1'b1, pack4(1, 1, 2, 1), '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    total++;
    if (tick !== '0 || reset_out !== 1'b1 || running !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_run got tick=%b rout=%b run=%b want tick=0 rout=1 run=0",
               tick, reset_out, running);
    end
    for (int k = 0; k < RC; k++) step(1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      total++;
      if (tick !== '0 || running !== 1'b1 || reset_out !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_silent cyc=%0d got tick=%b run=%b rout=%b want tick=0 run=1 rout=0",
                 k, tick, running, reset_out);
      end
    end
  endtask

  task automatic test_random();
    logic r, e, l;
    logic [CH*DW-1:0] dv, pv;
    e = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) e = ~e;
      l = ($urandom_range(0, 7) == 0);
      dv = pack4($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
      pv = pack4($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      step(r, e, l, dv, pv);
      total++;
      if (tick !== exp_tick() || running !== (mode == 2) || reset_out !== (mode == 0)) begin
        bad++;
        $display("FAIL random cyc=%0d got tick=%b run=%b rout=%b want tick=%b run=%b rout=%b",
                 c, tick, running, reset_out, exp_tick(), (mode == 2), (mode == 0));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin md[i] = 0; mp[i] = 0; end
    test_reset();
    test_divide();
`ifdef CLOCK_ENABLE_PHASE_EN
    test_phase();
`endif
    test_enable_toggle();
    test_load_midrun();
    test_reset_in_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
